// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter
//   Controls one barrier gate that is shared by the entry lane and the exit
//   lane. It latches request edges from the debounced buttons and refuses
//   entry when the lot is full. When both lanes are waiting, it serves them
//   in round-robin order. It runs the open / pass / close / guard sequence
//   and keeps the occupancy count.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   entry_btn    debounced entry request level
//   exit_btn     debounced exit request level
//   pass_sensor  debounced, high while a vehicle is under the gate
//   gate_open    registered, 1 = barrier raised
//   dir_in       registered, direction of current/last grant (1 = entry)
//   occupancy    registered count of parked vehicles
//   full         occupancy == CAPACITY
//   empty        occupancy == 0
//   grant_in     one-cycle pulse on an entry grant
//   grant_out    one-cycle pulse on an exit grant
//   reject       one-cycle pulse when an entry is refused (lot full)
//
// State table
//   state   | meaning
//   IDLE    | gate closed, arbitrating pending requests
//   OPEN    | gate raised, waiting up to OPEN_TIME for a vehicle
//   PASSING | vehicle under the gate, wait for it to clear (no timeout)
//   GUARD   | gate closed, hold-off before the next grant
module parking_gate_arbiter #(
  parameter int CAPACITY     = 8,
  parameter int CNT_W        = 4,
  parameter int OPEN_TIME    = 50_000_000,
  parameter int GUARD_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_btn,
  input  logic             exit_btn,
  input  logic             pass_sensor,
  output logic             gate_open,
  output logic             dir_in,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             grant_in,
  output logic             grant_out,
  output logic             reject
);

  localparam int TMAX = (OPEN_TIME > GUARD_CYCLES) ? OPEN_TIME : GUARD_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0]    OPEN_LOAD  = TW'(OPEN_TIME - 1);
  localparam logic [TW-1:0]    GUARD_LOAD = TW'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP        = CNT_W'(CAPACITY);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    PASSING = 2'd2,
    GUARD   = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [TW-1:0]    timer, timer_n;
  logic [CNT_W-1:0] occ_n;
  logic             gate_n, dir_n, gi_n, go_n, rj_n;
  logic             last_in, last_n;
  logic             pend_in, pend_out, pend_in_n, pend_out_n;
  logic             clr_in, clr_out, serve_in;
  logic             entry_q, exit_q;
  logic             entry_rise, exit_rise;

  assign full  = (occupancy == CAP);
  assign empty = (occupancy == '0);

  assign entry_rise = entry_btn & ~entry_q;
  assign exit_rise  = exit_btn & ~exit_q;

  // A set flag absorbs further edges. The flag is cleared only when it is
  // served or rejected.
  assign pend_in_n  = pend_in  ? ~clr_in  : entry_rise;
  assign pend_out_n = pend_out ? ~clr_out : exit_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      gate_open <= 1'b0;
      dir_in    <= 1'b0;
      occupancy <= '0;
      grant_in  <= 1'b0;
      grant_out <= 1'b0;
      reject    <= 1'b0;
      pend_in   <= 1'b0;
      pend_out  <= 1'b0;
      last_in   <= 1'b1;
      // A button that is held through reset must not look like a new press.
      entry_q   <= entry_btn;
      exit_q    <= exit_btn;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      gate_open <= gate_n;
      dir_in    <= dir_n;
      occupancy <= occ_n;
      grant_in  <= gi_n;
      grant_out <= go_n;
      reject    <= rj_n;
      pend_in   <= pend_in_n;
      pend_out  <= pend_out_n;
      last_in   <= last_n;
      entry_q   <= entry_btn;
      exit_q    <= exit_btn;
    end
  end

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    gate_n   = gate_open;
    dir_n    = dir_in;
    occ_n    = occupancy;
    last_n   = last_in;
    gi_n     = 1'b0;
    go_n     = 1'b0;
    rj_n     = 1'b0;
    clr_in   = 1'b0;
    clr_out  = 1'b0;
    serve_in = 1'b0;

    case (state)
      IDLE: begin
        if (pend_in && full) begin
          // The reject uses up this cycle. A waiting exit is served next cycle.
          clr_in = 1'b1;
          rj_n   = 1'b1;
        end else if (pend_in || pend_out) begin
          serve_in = pend_in && (!pend_out || !last_in);
          clr_in   = serve_in;
          clr_out  = !serve_in;
          last_n   = serve_in;
          dir_n    = serve_in;
          gi_n     = serve_in;
          go_n     = !serve_in;
          gate_n   = 1'b1;
          timer_n  = OPEN_LOAD;
          state_n  = OPEN;
        end
      end

      OPEN: begin
        if (pass_sensor) begin
          state_n = PASSING;
        end else if (timer == '0) begin
          gate_n  = 1'b0;
          timer_n = GUARD_LOAD;
          state_n = GUARD;
        end else begin
          timer_n = timer - TW'(1);
        end
      end

      PASSING: begin
        if (!pass_sensor) begin
          gate_n = 1'b0;
          if (dir_in) begin
            occ_n = (occupancy == CAP) ? occupancy : occupancy + CNT_W'(1);
          end else begin
            occ_n = (occupancy == '0) ? occupancy : occupancy - CNT_W'(1);
          end
          timer_n = GUARD_LOAD;
          state_n = GUARD;
        end
      end

      GUARD: begin
        if (timer == '0) begin
          state_n = IDLE;
        end else begin
          timer_n = timer - TW'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
module tb_parking_gate_arbiter;

  localparam int CAPACITY     = 2;
  localparam int CNT_W        = 4;
  localparam int OPEN_TIME    = 10;
  localparam int GUARD_CYCLES = 4;

  localparam int EV_NONE = 0;
  localparam int EV_GI   = 1;
  localparam int EV_GO   = 2;
  localparam int EV_RJ   = 3;
  localparam int EV_CL   = 4;

  typedef struct {
    int kind;
    int cyc;
    int occ;
  } ev_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             entry_btn, exit_btn, pass_sensor;
  logic             gate_open, dir_in, full, empty;
  logic             grant_in, grant_out, reject;
  logic [CNT_W-1:0] occupancy;

  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  int  m_occ  = 0;
  logic gate_prev = 1'b0;
  ev_t sb[$];

  parking_gate_arbiter #(
    .CAPACITY    (CAPACITY),
    .CNT_W       (CNT_W),
    .OPEN_TIME   (OPEN_TIME),
    .GUARD_CYCLES(GUARD_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .entry_btn  (entry_btn),
    .exit_btn   (exit_btn),
    .pass_sensor(pass_sensor),
    .gate_open  (gate_open),
    .dir_in     (dir_in),
    .occupancy  (occupancy),
    .full       (full),
    .empty      (empty),
    .grant_in   (grant_in),
    .grant_out  (grant_out),
    .reject     (reject)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at, input int occ);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.occ  = occ;
    sb.push_back(e);
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      chk("unexpected_event", kind, EV_NONE);
    end else begin
      e = sb.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_cycle", cyc, e.cyc);
      chk("ev_occupancy", int'(occupancy), e.occ);
      if (kind == EV_GI || kind == EV_GO) begin
        chk("grant_gate_open", int'(gate_open), 1);
        chk("grant_dir_in", int'(dir_in), (kind == EV_GI) ? 1 : 0);
      end
      if (kind == EV_CL) begin
        chk("close_full", int'(full), (e.occ == CAPACITY) ? 1 : 0);
        chk("close_empty", int'(empty), (e.occ == 0) ? 1 : 0);
      end
    end
  endtask

  // Outputs are sampled on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (grant_in)  check_ev(EV_GI);
    if (grant_out) check_ev(EV_GO);
    if (reject)    check_ev(EV_RJ);
    if (gate_prev && !gate_open) check_ev(EV_CL);
    gate_prev = gate_open;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    for (int i = 0; i < 1000 && cyc < target; i++) tick(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    m_occ = 0;
    chk("rst_gate_open", int'(gate_open), 0);
    chk("rst_occupancy", int'(occupancy), 0);
    chk("rst_dir_in", int'(dir_in), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    reset = 1'b0;
    tick(1);
  endtask

  // A vehicle passes under the gate for a grant made at gcyc. The task
  // returns once the arbiter is back in IDLE, at gcyc+11.
  task automatic pass_vehicle(input int gcyc, input bit is_in);
    wait_until(gcyc + 1);
    pass_sensor = 1'b1;
    tick(5);
    pass_sensor = 1'b0;
    if (is_in) m_occ = (m_occ == CAPACITY) ? m_occ : m_occ + 1;
    else       m_occ = (m_occ == 0) ? 0 : m_occ - 1;
    push(EV_CL, gcyc + 7, m_occ);
    tick(5);
  endtask

  task automatic do_entry();
    int c;
    c = cyc;
    entry_btn = 1'b1;
    push(EV_GI, c + 2, m_occ);
    tick(1);
    entry_btn = 1'b0;
    pass_vehicle(c + 2, 1'b1);
  endtask

  task automatic do_exit();
    int c;
    c = cyc;
    exit_btn = 1'b1;
    push(EV_GO, c + 2, m_occ);
    tick(1);
    exit_btn = 1'b0;
    pass_vehicle(c + 2, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset       = 1'b1;
    entry_btn   = 1'b0;
    exit_btn    = 1'b0;
    pass_sensor = 1'b0;
    tick(1);
    do_reset();

    // Normal entry with passage.
    do_entry();
    chk("occ_after_entry", int'(occupancy), 1);

    // Entry granted, but no vehicle arrives: the gate stays open for exactly
    // OPEN_TIME cycles and then closes.
    c = cyc;
    entry_btn = 1'b1;
    push(EV_GI, c + 2, m_occ);
    tick(1);
    entry_btn = 1'b0;
    push(EV_CL, c + 12, m_occ);
    tick(16);
    chk("occ_after_timeout", int'(occupancy), 1);

    // Fill the lot, then an entry request is rejected.
    do_entry();
    chk("full_at_capacity", int'(full), 1);
    c = cyc;
    entry_btn = 1'b1;
    push(EV_RJ, c + 2, m_occ);
    tick(1);
    entry_btn = 1'b0;
    tick(4);
    chk("occ_after_reject", int'(occupancy), 2);
    chk("gate_after_reject", int'(gate_open), 0);

    // Simultaneous entry and exit requests with occupancy = 1: OUT is served
    // first, then IN after the guard time, with no new press.
    do_reset();
    do_entry();
    c = cyc;
    entry_btn = 1'b1;
    exit_btn  = 1'b1;
    push(EV_GO, c + 2, m_occ);
    tick(1);
    entry_btn = 1'b0;
    exit_btn  = 1'b0;
    pass_vehicle(c + 2, 1'b0);
    push(EV_GI, c + 14, m_occ);
    pass_vehicle(c + 14, 1'b1);
    chk("occ_after_contention", int'(occupancy), 1);

    // entry_btn held through reset release gives no grant. A later edge does.
    entry_btn = 1'b1;
    do_reset();
    tick(6);
    entry_btn = 1'b0;
    tick(1);
    do_entry();
    chk("occ_after_held_btn", int'(occupancy), 1);

    // Reset during PASSING while an exit request is pending.
    c = cyc;
    entry_btn = 1'b1;
    push(EV_GI, c + 2, m_occ);
    tick(1);
    entry_btn = 1'b0;
    tick(2);
    pass_sensor = 1'b1;
    exit_btn    = 1'b1;
    tick(2);
    exit_btn = 1'b0;
    reset    = 1'b1;
    m_occ    = 0;
    push(EV_CL, c + 6, 0);
    tick(1);
    chk("midrst_gate_open", int'(gate_open), 0);
    chk("midrst_occupancy", int'(occupancy), 0);
    chk("midrst_empty", int'(empty), 1);
    reset       = 1'b0;
    pass_sensor = 1'b0;
    tick(8);

    // After reset the arbiter is in IDLE: an exit on an empty lot is granted
    // and the count stays at zero.
    do_exit();
    chk("occ_exit_empty", int'(occupancy), 0);
    do_entry();
    chk("occ_final", int'(occupancy), 1);

    tick(3);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
